// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: oversampled PS/2 device-to-host receiver feeding a scan-code FIFO
module ps2_keyboard_rx #(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  input  logic       rdn,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [2:0] pc_q, pc_d, pd_q, pd_d;
  logic [3:0] cnt_q, cnt_d;
  logic [10:0] sr_q, sr_d, frame;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0] count_q, count_d;
  logic overflow_q, overflow_d, frame_err_q, frame_err_d, rdn_q, rdn_d;
  logic [7:0] mem_q [DEPTH];
  logic fall, done, valid, timeout, push_req, push, pop, full;
  always_comb begin
    pc_d = {pc_q[1:0], PS2_clk};
    pd_d = {pd_q[1:0], PS2_data};
    fall = !pc_q[1] && pc_q[2];
    frame = {pd_q[1], sr_q[10:1]};
    done = fall && cnt_q == 4'd10;
    valid = !frame[0] && frame[10] && ^frame[9:1];
    timeout = cnt_q != 4'd0 && tcnt_q == TW'(TIMEOUT);
    sr_d = fall ? frame : sr_q;
    cnt_d = fall ? (done ? 4'd0 : cnt_q + 4'd1) : (timeout ? 4'd0 : cnt_q);
    tcnt_d = (fall || timeout || cnt_q == 4'd0) ? '0 : tcnt_q + TW'(1);
    frame_err_d = (done && !valid) || (timeout && !fall);
    rdn_d = rdn;
    pop = rdn_q && !rdn && ready;
    full = count_q == (FIFO_AW + 1)'(DEPTH);
    push_req = done && valid;
    // a full FIFO still accepts a code when the same cycle frees a slot
    push = push_req && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    overflow_d = overflow_q || (push_req && full && !pop);
  end
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      pc_q <= 3'b111;
      pd_q <= 3'b111;
      cnt_q <= '0;
      sr_q <= '0;
      tcnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      frame_err_q <= 1'b0;
      rdn_q <= 1'b1;
    end else begin
      pc_q <= pc_d;
      pd_q <= pd_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      tcnt_q <= tcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      frame_err_q <= frame_err_d;
      rdn_q <= rdn_d;
    end
  end
  always_ff @(posedge clk_100MHz) begin
    if (!rst && push) mem_q[wr_ptr_q] <= frame[8:1];
  end
  assign ready = count_q != '0;
  assign data = ready ? mem_q[rd_ptr_q] : 8'h00;
  assign overflow = overflow_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: scoreboard bench driving PS/2 frames and CPU reads
module tb_ps2_keyboard_rx;
  localparam int H = 20;
  localparam int TMO = 300;
  localparam int DEPTH = 8;
  logic clk, rst, PS2_clk, PS2_data, rdn;
  logic [7:0] data;
  logic ready, overflow, frame_err;
  int tests = 0, fails = 0, err_hi = 0, exp_err = 0;
  logic exp_ovf = 0;
  logic [7:0] exp_q [$];
  ps2_keyboard_rx #(.FIFO_AW(3), .TIMEOUT(TMO)) dut (
    .clk_100MHz(clk), .rst(rst), .PS2_clk(PS2_clk), .PS2_data(PS2_data), .rdn(rdn),
    .data(data), .ready(ready), .overflow(overflow), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (frame_err) err_hi <= err_hi + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic pop_at_push);
    logic [10:0] f;
    f = {1'b1, bad_par ? ^code : ~^code, code, 1'b0};
    for (int i = 0; i < 11; i++) begin
      PS2_data = f[i];
      repeat (H) @(negedge clk);
      PS2_clk = 0;
      if (i == 10) begin
        repeat (2) @(negedge clk);
        if (pop_at_push) begin
          chk("head_pre", data, exp_q[0]);
          rdn = 0;
        end
        @(negedge clk);
        if (bad_par) exp_err++;
        else if (pop_at_push) begin
          void'(exp_q.pop_front());
          exp_q.push_back(code);
        end else if (exp_q.size() == DEPTH) exp_ovf = 1;
        else exp_q.push_back(code);
        chk("ready", ready, exp_q.size() != 0);
        chk("count", dut.count_q, exp_q.size());
        chk("ovf", overflow, exp_ovf);
      end
      repeat (H) @(negedge clk);
      PS2_clk = 1;
    end
    rdn = 1;
    repeat (H) @(negedge clk);
    chk("ferr", err_hi, exp_err);
  endtask
  task automatic read_one();
    chk("rd_ready", ready, 1);
    chk("rd_data", data, exp_q.pop_front());
    rdn = 0;
    repeat (5) @(negedge clk);
    rdn = 1;
    repeat (2) @(negedge clk);
  endtask
  task automatic chk_empty();
    chk("empty_ready", ready, 0);
    chk("empty_data", data, 0);
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    exp_q.delete();
    exp_ovf = 0;
  endtask
  initial begin
    clk = 0;
    PS2_clk = 1;
    PS2_data = 1;
    rdn = 1;
    do_reset();
    chk("rst_data", data, 0);
    chk("rst_ready", ready, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    send_frame(8'h1C, 0, 0);
    read_one();
    chk_empty();
    send_frame(8'h1C, 1, 0);
    for (int i = 0; i < 4; i++) begin
      PS2_data = 0;
      repeat (H) @(negedge clk);
      PS2_clk = 0;
      repeat (H) @(negedge clk);
      PS2_clk = 1;
    end
    chk("tmo_pending", err_hi, exp_err);
    repeat (TMO + 10) @(negedge clk);
    exp_err++;
    chk("tmo_ferr", err_hi, exp_err);
    chk("tmo_cnt", dut.cnt_q, 0);
    send_frame(8'hF0, 0, 0);
    read_one();
    chk_empty();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
    for (int i = 0; i < 8; i++) read_one();
    chk_empty();
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("rst2_ovf", overflow, 0);
    chk_empty();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 0);
    send_frame(8'h09, 0, 1);
    for (int i = 0; i < 8; i++) read_one();
    chk_empty();
    chk("final_ovf", overflow, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver sitting directly upstream of the TankBattle CPU's keyboard I/O port. It oversamples the raw PS2_clk/PS2_data pins on the system clock, assembles 11-bit device-to-host frames, checks start, parity and stop bits, and queues valid scan codes in a small FIFO. The CPU drains the FIFO through an active-low read strobe.

## Interface
- FIFO_AW, 3: FIFO address width; depth = 2^FIFO_AW entries (8).
- TIMEOUT, 100000: clk_100MHz cycles without a PS2_clk falling edge before a partial frame is discarded (1 ms).

- clk_100MHz  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- PS2_clk  input  1  raw keyboard clock pin (asynchronous).
- PS2_data  input  1  raw keyboard data pin (asynchronous).
- rdn  input  1  active-low read strobe from the CPU; pops on its 1->0 transition.
- data  output  8  scan code at the FIFO head; 0 when empty.
- ready  output  1  FIFO not empty.
- overflow  output  1  sticky flag: a valid code was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

## Operation
- Synchronizer: PS2_clk and PS2_data each pass through a 3-flop chain (s0->s1->s2).
- Falling edge: fall = s1==0 && s2==1 on the clock chain. The data bit sampled is data s1 in the same cycle.
- Shift state: bit counter cnt 0..10 and an 11-bit shift register; bits arrive LSB-first.
  - IDLE (cnt=0), then RECV (cnt 1..10).
  - On each fall: store the bit and increment cnt.
  - On the fall with cnt==10: the frame is complete and cnt returns to 0.
- Frame check:
  - Valid when start==0, stop==1, and XOR of the 8 data bits plus parity == 1 (odd parity).
  - Valid frame: push data[7:0].
  - Invalid frame: pulse frame_err and push nothing.
- Timeout: a cycle counter clears on every fall and increments while cnt!=0. When it reaches TIMEOUT, cnt is set to 0 and frame_err pulses. The counter is idle while cnt==0.
- FIFO: circular buffer with wr_ptr and rd_ptr of width FIFO_AW and a count of width FIFO_AW+1. data is the combinational read of mem[rd_ptr], gated to 0 when empty.
- Pop: rdn_d is rdn registered (reset value 1). Pop when rdn_d==1 && rdn==0 && ready. Holding rdn low pops exactly once.
- Boundary rules:
  - Push while full: no pop that cycle means the code is dropped and overflow is set. Pop the same cycle means both occur, count is unchanged, and overflow is not set.
  - Push and pop on a non-full, non-empty FIFO: count is unchanged.
  - Pop while empty: ignored; pointers are unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
  - overflow clears only on rst.

## Timing
- Reset values: data=0, ready=0, overflow=0, frame_err=0. Synchronizers reset to 1. cnt=0, pointers=0, count=0, rdn_d=1.
- A rst asserted mid-frame or mid-read discards the partial frame and all queued codes on that edge.
- Latency: a PS2_clk pin fall set up before edge k makes fall true in the cycle after edge k+1. The push commits on edge k+2, so ready is high after edge k+2.
- Pop: on the edge that samples rdn falling, rd_ptr advances. data shows the next entry (or 0) after that edge.
- frame_err is high for exactly the one cycle following the decision edge.
- Throughput: one push and one pop per cycle maximum. PS/2 bit rate (10–16.7 kHz) is far below this.

## Test plan
- Reset: hold rst 2 cycles with pins at 1 -> data=0, ready=0, overflow=0, frame_err=0.
- Valid frame: drive code 0x1C as bits 0,0,0,1,1,1,0,0,0,0,1 (start, LSB-first data, parity 0, stop) at a 12 kHz clock -> ready=1 and data=0x1C within 3 cycles of the 11th fall. Then rdn low for 5 cycles -> one pop, ready=0, data=0.
- Parity error: send 0x1C with parity 1 -> frame_err pulses once, ready stays 0.
- Timeout: send 4 bits, then idle for TIMEOUT+10 cycles -> frame_err pulses, cnt=0. A following valid 0xF0 frame is then received correctly.
- Overflow: send 9 valid codes 0x01..0x09 with no reads -> overflow=1 and count=8. Eight reads return 0x01..0x08, then ready=0.
- Full with simultaneous push and pop: fill with 8 codes and time a rdn fall to the same cycle as the 9th push -> overflow stays 0, count=8, and the head sequence is 0x02..0x09.
